thermal_throttle_ctrl: RTL and testbench



---
 rtl/thermal_throttle_ctrl.sv | 72 +++++++
 tb/tb_thermal_throttle_ctrl.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/thermal_throttle_ctrl.sv
// thermal_throttle_ctrl: temperature-state to clock-enable pulse train with dwell hysteresis on cool-down.
// Optional sticky emergency stop on all-ones temp_st when THERM_EMERG_STOP_EN is defined.
module thermal_throttle_ctrl #(
  parameter int TEMP_W = 3,
  parameter int DIV_W  = 8,
  parameter int DIV_L0 = 1,
  parameter int DIV_L1 = 2,
  parameter int DIV_L2 = 4,
  parameter int DIV_L3 = 8,
  parameter int DWELL  = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [TEMP_W-1:0] temp_st,
  input  logic              halt_i,
  output logic              clk_en_o,
  output logic [1:0]        cur_lvl_o,
  output logic              lvl_chg_o,
  output logic              throttled_o,
  output logic [CNT_W-1:0]  en_cnt_o,
  output logic              emerg_o
);
  localparam int DWL_W = $clog2(DWELL + 2);
  localparam logic [DIV_W-1:0] D0 = (DIV_L0 == 0) ? DIV_W'(1) : DIV_W'(DIV_L0);
  localparam logic [DIV_W-1:0] D1 = (DIV_L1 == 0) ? DIV_W'(1) : DIV_W'(DIV_L1);
  localparam logic [DIV_W-1:0] D2 = (DIV_L2 == 0) ? DIV_W'(1) : DIV_W'(DIV_L2);
  localparam logic [DIV_W-1:0] D3 = (DIV_L3 == 0) ? DIV_W'(1) : DIV_W'(DIV_L3);
  logic [DIV_W-1:0] cnt, cnt_nxt, div_cur;
  logic [DWL_W-1:0] dwell_cnt, dwell_nxt;
  logic [1:0]       lvl_req, prev_req, lvl_nxt;
  logic             emerg_nxt, run, bnd, dwell_met, cooler;
  always_comb begin
    lvl_req   = (temp_st > TEMP_W'(3)) ? 2'd3 : temp_st[1:0];
`ifdef THERM_EMERG_STOP_EN
    emerg_nxt = emerg_o | (&temp_st);
`else
    emerg_nxt = 1'b0;
`endif
    div_cur   = (cur_lvl_o == 2'd0) ? D0 : (cur_lvl_o == 2'd1) ? D1 : (cur_lvl_o == 2'd2) ? D2 : D3;
    run       = !halt_i && !emerg_nxt;
    bnd       = run && (cnt == div_cur - DIV_W'(1));
    cnt_nxt   = (!run || bnd) ? '0 : cnt + DIV_W'(1);
    cooler    = (lvl_req < cur_lvl_o) && (lvl_req == prev_req);
    // dwell_met drops immediately if the request moves, even with a full counter
    dwell_met = cooler && (dwell_cnt >= DWL_W'(DWELL));
    dwell_nxt = !cooler ? '0 : (dwell_cnt >= DWL_W'(DWELL)) ? dwell_cnt : dwell_cnt + DWL_W'(1);
    lvl_nxt   = emerg_nxt ? 2'd3 : (bnd && (lvl_req > cur_lvl_o || dwell_met)) ? lvl_req : cur_lvl_o;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt         <= '0;
      dwell_cnt   <= '0;
      prev_req    <= '0;
      cur_lvl_o   <= '0;
      clk_en_o    <= 1'b0;
      lvl_chg_o   <= 1'b0;
      throttled_o <= 1'b0;
      en_cnt_o    <= '0;
      emerg_o     <= 1'b0;
    end else begin
      cnt         <= cnt_nxt;
      dwell_cnt   <= dwell_nxt;
      prev_req    <= lvl_req;
      cur_lvl_o   <= lvl_nxt;
      clk_en_o    <= bnd;
      lvl_chg_o   <= lvl_nxt != cur_lvl_o;
      throttled_o <= lvl_nxt != 2'd0;
      en_cnt_o    <= (bnd && !(&en_cnt_o)) ? en_cnt_o + CNT_W'(1) : en_cnt_o;
      emerg_o     <= emerg_nxt;
    end
endmodule

// File: tb/tb_thermal_throttle_ctrl.sv
// tb_thermal_throttle_ctrl: scoreboard bench; a cycle model pushes expected outputs, compared one edge later.
module tb_thermal_throttle_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  temp_st = '0;
  logic        halt_i = 1'b0;
  logic        clk_en_o, lvl_chg_o, throttled_o, emerg_o;
  logic [1:0]  cur_lvl_o;
  logic [15:0] en_cnt_o;
  int n_cmp = 0;
  int n_bad = 0;
  int pulses;
  typedef struct {
    logic        en;
    logic [1:0]  lvl;
    logic        chg;
    logic        thr;
    logic [15:0] ecnt;
    logic        em;
  } exp_t;
  exp_t sbq[$];
  int m_cnt, m_lvl, m_prev, m_dwell, m_ecnt;
  bit m_em;
  thermal_throttle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .temp_st(temp_st), .halt_i(halt_i),
    .clk_en_o(clk_en_o), .cur_lvl_o(cur_lvl_o), .lvl_chg_o(lvl_chg_o),
    .throttled_o(throttled_o), .en_cnt_o(en_cnt_o), .emerg_o(emerg_o)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic m_reset();
    m_cnt = 0; m_lvl = 0; m_prev = 0; m_dwell = 0; m_ecnt = 0; m_em = 0;
    sbq.delete();
  endtask
  function automatic int divof(input int l);
    int d[4] = '{1, 2, 4, 8};
    return d[l];
  endfunction
  task automatic step();
    exp_t e;
    int req, nl;
    bit em_n, fire, met;
    req = (temp_st > 3) ? 3 : int'(temp_st);
    em_n = m_em;
`ifdef THERM_EMERG_STOP_EN
    if (temp_st == 3'b111) em_n = 1;
`endif
    fire = 0;
    if (halt_i || em_n) m_cnt = 0;
    else if (m_cnt == divof(m_lvl) - 1) begin m_cnt = 0; fire = 1; end
    else m_cnt++;
    met = (m_dwell >= 16) && (req == m_prev) && (req < m_lvl);
    if (em_n) nl = 3;
    else if (fire && (req > m_lvl || met)) nl = req;
    else nl = m_lvl;
    if (req < m_lvl && req == m_prev) m_dwell = (m_dwell >= 16) ? 16 : m_dwell + 1;
    else m_dwell = 0;
    if (fire && m_ecnt != 16'hffff) m_ecnt++;
    e.en = fire; e.lvl = 2'(nl); e.chg = (nl != m_lvl); e.thr = (nl != 0);
    e.ecnt = 16'(m_ecnt); e.em = em_n;
    m_lvl = nl; m_prev = req; m_em = em_n;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    check("clk_en", clk_en_o, e.en);
    check("cur_lvl", cur_lvl_o, e.lvl);
    check("lvl_chg", lvl_chg_o, e.chg);
    check("throttled", throttled_o, e.thr);
    check("en_cnt", en_cnt_o, e.ecnt);
    check("emerg", emerg_o, e.em);
    if (clk_en_o) pulses++;
  endtask
  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask
  task automatic until_lvl(input int l, input int budget);
    for (int i = 0; i < budget && cur_lvl_o != 2'(l); i++) step();
    check("reach_lvl", cur_lvl_o, l);
  endtask
  task automatic check_zero(input string tag);
    check({tag, "_en"}, clk_en_o, 0);
    check({tag, "_lvl"}, cur_lvl_o, 0);
    check({tag, "_chg"}, lvl_chg_o, 0);
    check({tag, "_thr"}, throttled_o, 0);
    check({tag, "_ecnt"}, en_cnt_o, 0);
    check({tag, "_em"}, emerg_o, 0);
  endtask
  task automatic async_reset();
    #3 rst_n = 1'b0;
    #1 check_zero("async_rst");
    m_reset();
    #2 rst_n = 1'b1;
  endtask
  initial begin
    m_reset();
    #22 check_zero("reset");
    rst_n = 1'b1;
    steps(10);
    check("div1_ecnt10", en_cnt_o, 10);
    check("div1_en", clk_en_o, 1);
    temp_st = 3'd2;
    step();
    check("esc2_lvl", cur_lvl_o, 2);
    check("esc2_chg", lvl_chg_o, 1);
    check("esc2_thr", throttled_o, 1);
    pulses = 0;
    steps(12);
    check("div4_pulses", pulses, 3);
    temp_st = 3'd3;
    until_lvl(3, 20);
    temp_st = 3'd1;
    steps(10);
    temp_st = 3'd3;
    step();
    check("interrupted_dwell", cur_lvl_o, 3);
    temp_st = 3'd1;
    steps(16);
    check("dwell_hold", cur_lvl_o, 3);
    until_lvl(1, 40);
    check("deesc_chg", lvl_chg_o, 1);
    check("deesc_on_boundary", clk_en_o, 1);
    pulses = 0;
    steps(8);
    check("div2_pulses", pulses, 4);
    temp_st = 3'd3;
    until_lvl(3, 20);
    steps(2);
    halt_i = 1'b1;
    pulses = 0;
    steps(20);
    check("halt_pulses", pulses, 0);
    halt_i = 1'b0;
    steps(7);
    check("halt_release_quiet", pulses, 0);
    step();
    check("halt_release_pulse", clk_en_o, 1);
    async_reset();
    temp_st = 3'd5;
    step();
    check("clamp_lvl", cur_lvl_o, 3);
    pulses = 0;
    steps(16);
    check("div8_pulses", pulses, 2);
    steps(3);
    async_reset();
    temp_st = 3'd7;
    step();
    check("all_ones_lvl", cur_lvl_o, 3);
`ifdef THERM_EMERG_STOP_EN
    check("emerg_set", emerg_o, 1);
    check("emerg_en", clk_en_o, 0);
    temp_st = 3'd0;
    pulses = 0;
    steps(20);
    check("emerg_sticky", emerg_o, 1);
    check("emerg_no_pulses", pulses, 0);
`else
    check("no_emerg", emerg_o, 0);
    temp_st = 3'd0;
    steps(20);
`endif
    async_reset();
    steps(3);
    check("post_reset_ecnt", en_cnt_o, 3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
